// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: turns the async FIFO read port (1-cycle latency) into a valid/ready stream.
// Optional STREAM_WORD_COUNT_EN adds the word_count delivered-word counter output.
module fifo_rd_stream_adapter #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic                 r_clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [width-1:0]     fifo_data,
    output logic                 fifo_r_en,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [width-1:0]     m_data
`ifdef STREAM_WORD_COUNT_EN
    ,
    output logic [cnt_width-1:0] word_count
`endif
);

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t             occ, occ_next;
    logic             inflight;
    logic [width-1:0] head, head_next;
    logic [width-1:0] tail, tail_next;
    logic             pop;
    logic [1:0]       held;
    logic [2:0]       level;

    assign m_valid = (occ != OCC_0);
    assign m_data  = head;
    assign pop     = m_valid && m_ready;

    always_comb begin
        held = 2'd0;
        case (occ)
            OCC_1:   held = 2'd1;
            OCC_2:   held = 2'd2;
            default: held = 2'd0;
        endcase
    end

    // Credit: words held plus the one in flight, net of this cycle's pop, must leave room.
    assign level     = 3'(held) + 3'(inflight) - 3'(pop);
    assign fifo_r_en = !fifo_empty && !flush && !rst && (level < 3'd2);

    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        if (flush) begin
            occ_next = OCC_0;
        end else begin
            case (occ)
                OCC_0: begin
                    if (inflight) begin
                        head_next = fifo_data;
                        occ_next  = OCC_1;
                    end
                end
                OCC_1: begin
                    if (inflight && pop) begin
                        head_next = fifo_data;
                    end else if (inflight) begin
                        tail_next = fifo_data;
                        occ_next  = OCC_2;
                    end else if (pop) begin
                        occ_next = OCC_0;
                    end
                end
                OCC_2: begin
                    if (pop) begin
                        head_next = tail;
                        occ_next  = OCC_1;
                        if (inflight) begin
                            tail_next = fifo_data;
                            occ_next  = OCC_2;
                        end
                    end
                end
                default: occ_next = OCC_0;
            endcase
        end
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            occ      <= OCC_0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_r_en;
            head     <= head_next;
            tail     <= tail_next;
        end
    end

`ifdef STREAM_WORD_COUNT_EN
    always_ff @(posedge r_clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (pop && !flush) begin
            word_count <= word_count + 1'b1;
        end
    end
`else
    localparam int unused_cnt_width = cnt_width;
`endif

    overflow_never: assert property (@(posedge r_clk) disable iff (rst || flush)
        !(inflight && (occ == OCC_2) && !pop));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter against a behavioural FIFO read port.
module tb_fifo_rd_stream_adapter;

    localparam int width     = 8;
    localparam int cnt_width = 4;

    logic             r_clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty;
    logic [width-1:0] fifo_data = '0;
    logic             fifo_r_en;
    logic             flush = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [width-1:0] m_data;
`ifdef STREAM_WORD_COUNT_EN
    logic [cnt_width-1:0] word_count;
`endif

    fifo_rd_stream_adapter #(
        .width     (width),
        .cnt_width (cnt_width)
    ) dut (
        .r_clk      (r_clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef STREAM_WORD_COUNT_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 r_clk = ~r_clk;

    // FIFO read port model: registered data_out, one-cycle read latency.
    logic [width-1:0] mem [0:255];
    logic [8:0]       wr_ptr = '0;
    logic [8:0]       rd_ptr = '0;
    logic [width-1:0] pend [$];

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge r_clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 9'd1;
        end
    end

    int               checks = 0;
    int               errors = 0;
    logic [width-1:0] got [0:31];
    int               got_cyc [0:31];
    int               ngot;
    int               nreads;
    int               pc;

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic begin_phase();
        ngot   = 0;
        nreads = 0;
        pc     = 0;
    endtask

    // One clock cycle: load pending FIFO words, drive inputs, then observe the settled cycle.
    task automatic run_cycle(input logic rdy, input logic fl, input logic rs);
        @(negedge r_clk);
        while (pend.size() > 0) begin
            mem[wr_ptr[7:0]] = pend.pop_front();
            wr_ptr = wr_ptr + 9'd1;
        end
        m_ready = rdy;
        flush   = fl;
        rst     = rs;
        #1;
        if (m_valid && m_ready && !flush && !rst && ngot < 32) begin
            got[ngot]     = m_data;
            got_cyc[ngot] = pc;
            ngot++;
        end
        if (fifo_r_en && !fifo_empty) nreads++;
        pc++;
    endtask

    initial begin
        begin_phase();

        pend.push_back(8'hA5);
        for (int i = 0; i < 2; i++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            check_eq("rst_ren", 32'(fifo_r_en), 32'd0);
            check_eq("rst_valid", 32'(m_valid), 32'd0);
            check_eq("rst_data", 32'(m_data), 32'd0);
        end

        begin_phase();
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("single_ren_T", 32'(fifo_r_en), 32'd1);
        check_eq("single_valid_T", 32'(m_valid), 32'd0);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("single_valid_T1", 32'(m_valid), 32'd0);
        check_eq("single_ren_T1", 32'(fifo_r_en), 32'd0);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("single_valid_T2", 32'(m_valid), 32'd1);
        check_eq("single_data_T2", 32'(m_data), 32'hA5);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("single_valid_T3", 32'(m_valid), 32'd0);
        check_eq("single_ren_T3", 32'(fifo_r_en), 32'd0);
        check_eq("single_reads", 32'(nreads), 32'd1);

        for (int i = 0; i < 16; i++) pend.push_back(8'(i));
        begin_phase();
        for (int c = 0; c < 20; c++) run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("stream_count", 32'(ngot), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq("stream_data", 32'(got[i]), 32'(i));
            check_eq("stream_cycle", 32'(got_cyc[i]), 32'(i + 2));
        end

        for (int i = 0; i < 8; i++) pend.push_back(8'(i));
        begin_phase();
        for (int c = 0; c < 10; c++) run_cycle(1'b0, 1'b0, 1'b0);
        check_eq("bp_reads", 32'(nreads), 32'd2);
        check_eq("bp_valid", 32'(m_valid), 32'd1);
        check_eq("bp_data", 32'(m_data), 32'd0);
        check_eq("bp_ren", 32'(fifo_r_en), 32'd0);
        for (int c = 0; c < 14; c++) run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("bp_count", 32'(ngot), 32'd8);
        for (int i = 0; i < 8; i++) check_eq("bp_order", 32'(got[i]), 32'(i));

        for (int i = 0; i < 6; i++) pend.push_back(8'h10 + 8'(i));
        begin_phase();
        for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0, 1'b0);
        check_eq("fl_valid_pre", 32'(m_valid), 32'd1);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("fl_read_at_full", 32'(fifo_r_en), 32'd1);
        check_eq("fl_head_pre", 32'(m_data), 32'h10);
        run_cycle(1'b1, 1'b1, 1'b0);
        check_eq("fl_ren_in_flush", 32'(fifo_r_en), 32'd0);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("fl_valid_after", 32'(m_valid), 32'd0);
        for (int c = 0; c < 8; c++) run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("fl_count", 32'(ngot), 32'd4);
        check_eq("fl_word0", 32'(got[0]), 32'h10);
        check_eq("fl_word1", 32'(got[1]), 32'h13);
        check_eq("fl_word2", 32'(got[2]), 32'h14);
        check_eq("fl_word3", 32'(got[3]), 32'h15);
        check_eq("fl_reads", 32'(nreads), 32'd6);

        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b1);
`ifdef STREAM_WORD_COUNT_EN
        check_eq("cnt_rst", 32'(word_count), 32'd0);
`endif
        for (int i = 0; i < 17; i++) pend.push_back(8'h40 + 8'(i));
        begin_phase();
        for (int c = 0; c < 22; c++) run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("wrap_count", 32'(ngot), 32'd17);
        check_eq("wrap_last", 32'(got[16]), 32'h50);
`ifdef STREAM_WORD_COUNT_EN
        check_eq("cnt_wrap", 32'(word_count), 32'd1);
`endif

        pend.push_back(8'h60);
        pend.push_back(8'h61);
        for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0, 1'b0);
        check_eq("cf_valid_pre", 32'(m_valid), 32'd1);
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_eq("cf_valid_after", 32'(m_valid), 32'd0);
`ifdef STREAM_WORD_COUNT_EN
        check_eq("cnt_flush_hold", 32'(word_count), 32'd1);
`endif
        run_cycle(1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_eq("post_rst_valid", 32'(m_valid), 32'd0);
`ifdef STREAM_WORD_COUNT_EN
        check_eq("cnt_rst_clear", 32'(word_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
